// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alufunc_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

  function automatic logic is_muldiv(input alufunc_t f);
    return f inside {ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  // MULT is grouped with the signed ops because its word form sign-extends its operands
  function automatic logic is_signed_op(input alufunc_t f);
    return f inside {ALU_MULT, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_rem_op(input alufunc_t f);
    return f inside {ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide, one bit per cycle.
// Word ops run 32 iterations on a dividend pre-shifted to the top of the register.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  alufunc_t        alufunc,
  input  logic            is_word,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_X = CW'(XLEN);
  localparam logic [CW-1:0] CNT_W = CW'(WLEN);

  muldiv_state_t   r_state, w_next;
  alufunc_t        r_op;
  logic            r_word, r_sign_q, r_sign_r;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc, r_opx, r_opy, r_result;

  logic            w_sgn, w_neg_a, w_neg_b, w_div_zero, w_div_ovf, w_accept, w_qbit;
  logic [XLEN-1:0] w_opa, w_opb, w_mag_a, w_mag_b, w_dvd, w_min;
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_rem_nx, w_prod_nx, w_q, w_r, w_raw, w_final;

  // Operand preparation: word extension, magnitudes and special-case detection
  always_comb begin
    w_sgn = is_signed_op(alufunc);
    w_opa = a;
    w_opb = b;
    if (is_word) begin
      w_opa = w_sgn ? {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]} : {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]};
      w_opb = w_sgn ? {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]} : {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]};
    end
    w_neg_a    = w_sgn & w_opa[XLEN-1];
    w_neg_b    = w_sgn & w_opb[XLEN-1];
    w_mag_a    = w_neg_a ? -w_opa : w_opa;
    w_mag_b    = w_neg_b ? -w_opb : w_opb;
    w_dvd      = is_word ? (w_mag_a << (XLEN-WLEN)) : w_mag_a;
    w_min      = is_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_div_zero = (w_opb == '0);
    w_div_ovf  = (alufunc inside {ALU_DIV, ALU_REM}) && (w_opa == w_min) && (w_opb == '1);
  end

  // One iteration step of the shift-add multiplier and the restoring divider
  always_comb begin
    w_prod_nx = r_acc + (r_opy[0] ? r_opx : '0);
    w_shift   = {r_acc, r_opy[XLEN-1]};
    w_diff    = w_shift - {1'b0, r_opx};
    w_qbit    = ~w_diff[XLEN];
    w_rem_nx  = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  end

  // Final sign fix-up, result selection and word sign-extension
  always_comb begin
    w_q = r_sign_q ? -r_opy : r_opy;
    w_r = r_sign_r ? -r_acc : r_acc;
    if (r_op == ALU_MULT)   w_raw = r_acc;
    else if (is_rem_op(r_op)) w_raw = w_r;
    else                      w_raw = w_q;
    w_final = r_word ? {{(XLEN-WLEN){w_raw[WLEN-1]}}, w_raw[WLEN-1:0]} : w_raw;
  end

  // Next-state logic; special-case divides skip straight to DONE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid && is_muldiv(alufunc) && !flush) begin
          w_accept = 1'b1;
          if (alufunc == ALU_MULT)          w_next = MUL;
          else if (w_div_zero || w_div_ovf) w_next = DONE;
          else                              w_next = DIV;
        end
      end
      MUL, DIV: begin
        if (flush)                   w_next = IDLE;
        else if (r_cnt == CW'(1))    w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign ready  = (r_state == IDLE);
  assign done   = (r_state == DONE) && !flush;
  assign result = done ? w_final : r_result;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Datapath registers: load on accept, iterate while busy, hold on flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op     <= ALU_ADD;
      r_word   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opx    <= '0;
      r_opy    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= alufunc;
            r_word   <= is_word;
            r_cnt    <= is_word ? CNT_W : CNT_X;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_acc    <= '0;
            if (alufunc == ALU_MULT) begin
              r_opx <= w_opa;
              r_opy <= w_opb;
            end else if (w_div_zero) begin
              r_opy <= '1;
              r_acc <= w_opa;
            end else if (w_div_ovf) begin
              r_opy <= w_opa;
            end else begin
              r_opx    <= w_mag_b;
              r_opy    <= w_dvd;
              r_sign_q <= w_neg_a ^ w_neg_b;
              r_sign_r <= w_neg_a;
            end
          end
        end
        MUL: begin
          if (!flush) begin
            r_acc <= w_prod_nx;
            r_opx <= r_opx << 1;
            r_opy <= r_opy >> 1;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DIV: begin
          if (!flush) begin
            r_acc <= w_rem_nx;
            r_opy <= {r_opy[XLEN-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (!flush) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule
